// File: rtl/cache_def_pkg.sv
// Shared types and address-split constants for the direct-mapped cache controller.
package cache_def_pkg;

    localparam int TAGMSB      = 31;
    localparam int TAGLSB      = 14;
    localparam int CACHE_INDEX = 1024;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COMPARE_TAG = 2'd1,
        ALLOCATE    = 2'd2,
        WRITE_BACK  = 2'd3
    } cache_state_type;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAGMSB:TAGLSB] tag;
    } cache_tag_type;

    typedef struct packed {
        logic [9:0] index;
        logic       we;
    } cache_req_type;

    typedef logic [127:0] cache_data_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

    function automatic logic [31:0] get_word(input cache_data_type line, input logic [1:0] sel);
        return line[{sel, 5'd0} +: 32];
    endfunction

    function automatic cache_data_type put_word(input cache_data_type line, input logic [1:0] sel,
                                                input logic [31:0] word);
        cache_data_type res;
        res = line;
        res[{sel, 5'd0} +: 32] = word;
        return res;
    endfunction

endpackage

// File: rtl/dm_cache_stats.sv
// Saturating hit/miss event counters for the cache controller.
// Latency: counts update on the edge after the event pulse.
// Backpressure: none; pulses are consumed every cycle.
module dm_cache_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hit_inc,
    input  logic        miss_inc,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc && (hit_cnt != 32'hFFFF_FFFF))
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_inc && (miss_cnt != 32'hFFFF_FFFF))
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/dm_cache_fsm.sv
// Direct-mapped write-back/write-allocate cache controller; CACHE_STATS_EN adds hit/miss counters.
// Latency: hit answered one cycle after acceptance; misses add write-back and fill waits.
// Backpressure: CPU requests taken only in IDLE; mem_req held until mem_data.ready pulses.
module dm_cache_fsm
    import cache_def_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  cpu_req_type    cpu_req,
    output cpu_result_type cpu_res,
    output mem_req_type    mem_req,
    input  mem_data_type   mem_data,
    output cache_req_type  tag_req,
    output cache_req_type  data_req,
    output cache_tag_type  tag_write,
    input  cache_tag_type  tag_read,
    output cache_data_type data_write,
    input  cache_data_type data_read
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]    hit_cnt,
    output logic [31:0]    miss_cnt
`endif
);

    cache_state_type      state_q;
    logic [TAGMSB:TAGLSB] req_tag_q;
    logic [9:0]           req_index_q;
    logic [1:0]           req_word_q;
    logic [31:0]          req_data_q;
    logic                 req_rw_q;
    logic                 hit;
    logic                 unused_addr_bits;

    // Byte-lane bits never reach the cache; word granularity only.
    assign unused_addr_bits = ^cpu_req.addr[1:0];

    assign hit = tag_read.valid && (tag_read.tag == req_tag_q);

    always_comb begin
        cpu_res        = '0;
        tag_req        = '0;
        data_req       = '0;
        tag_write      = '0;
        data_write     = '0;
        tag_req.index  = req_index_q;
        data_req.index = req_index_q;
        case (state_q)
            COMPARE_TAG: begin
                if (hit) begin
                    cpu_res.ready = 1'b1;
                    cpu_res.data  = get_word(data_read, req_word_q);
                    if (req_rw_q) begin
                        tag_req.we      = 1'b1;
                        data_req.we     = 1'b1;
                        tag_write.valid = 1'b1;
                        tag_write.dirty = 1'b1;
                        tag_write.tag   = req_tag_q;
                        data_write      = put_word(data_read, req_word_q, req_data_q);
                    end
                end
            end
            ALLOCATE: begin
                // Fill lands as a clean line; a pending write merges on the re-compare.
                if (mem_data.ready) begin
                    tag_req.we      = 1'b1;
                    data_req.we     = 1'b1;
                    tag_write.valid = 1'b1;
                    tag_write.dirty = 1'b0;
                    tag_write.tag   = req_tag_q;
                    data_write      = mem_data.data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_tag_q   <= '0;
            req_index_q <= '0;
            req_word_q  <= '0;
            req_data_q  <= '0;
            req_rw_q    <= 1'b0;
            mem_req     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req.valid) begin
                        req_tag_q   <= cpu_req.addr[TAGMSB:TAGLSB];
                        req_index_q <= cpu_req.addr[13:4];
                        req_word_q  <= cpu_req.addr[3:2];
                        req_data_q  <= cpu_req.data;
                        req_rw_q    <= cpu_req.rw;
                        state_q     <= COMPARE_TAG;
                    end
                end
                COMPARE_TAG: begin
                    if (hit) begin
                        state_q <= IDLE;
                    end else if (tag_read.valid && tag_read.dirty) begin
                        mem_req.addr  <= {tag_read.tag, req_index_q, 4'h0};
                        mem_req.data  <= data_read;
                        mem_req.rw    <= 1'b1;
                        mem_req.valid <= 1'b1;
                        state_q       <= WRITE_BACK;
                    end else begin
                        mem_req.addr  <= {req_tag_q, req_index_q, 4'h0};
                        mem_req.rw    <= 1'b0;
                        mem_req.valid <= 1'b1;
                        state_q       <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (mem_data.ready) begin
                        mem_req.addr  <= {req_tag_q, req_index_q, 4'h0};
                        mem_req.rw    <= 1'b0;
                        mem_req.valid <= 1'b1;
                        state_q       <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_data.ready) begin
                        mem_req.valid <= 1'b0;
                        state_q       <= COMPARE_TAG;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic refill_q;

    // Marks the re-compare after a fill so the same request is not counted twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            refill_q <= 1'b0;
        else if (state_q == ALLOCATE && mem_data.ready)
            refill_q <= 1'b1;
        else if (state_q == COMPARE_TAG)
            refill_q <= 1'b0;
    end

    dm_cache_stats u_stats (
        .clk      (clk),
        .rst_n    (rst_n),
        .hit_inc  ((state_q == COMPARE_TAG) && hit && !refill_q),
        .miss_inc ((state_q == COMPARE_TAG) && !hit),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );
`endif

endmodule

// File: tb/tb_dm_cache_fsm.sv
// Bench for dm_cache_fsm: scripted scenarios then random traffic against a flat-memory cache model.
module tb_dm_cache_fsm;
    import cache_def_pkg::*;

    typedef struct {
        logic [31:0]  addr;
        logic         rw;
        logic [127:0] data;
    } xfer_t;

    logic           clk = 1'b0;
    logic           rst_n;
    cpu_req_type    cpu_req;
    cpu_result_type cpu_res;
    mem_req_type    mem_req;
    mem_data_type   mem_data;
    cache_req_type  tag_req, data_req;
    cache_tag_type  tag_write, tag_read;
    cache_data_type data_write, data_read;
`ifdef CACHE_STATS_EN
    logic [31:0]    hit_cnt, miss_cnt;
`endif

    dm_cache_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_res    (cpu_res),
        .mem_req    (mem_req),
        .mem_data   (mem_data),
        .tag_req    (tag_req),
        .data_req   (data_req),
        .tag_write  (tag_write),
        .tag_read   (tag_read),
        .data_write (data_write),
        .data_read  (data_read)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Tag/data memories: combinational read, write on the clock edge.
    cache_tag_type  tag_mem  [CACHE_INDEX];
    cache_data_type data_mem [CACHE_INDEX];
    logic           mem_inited = 1'b0;

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < CACHE_INDEX; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
            mem_inited <= 1'b1;
        end else begin
            if (tag_req.we)  tag_mem[tag_req.index]   <= tag_write;
            if (data_req.we) data_mem[data_req.index] <= data_write;
        end
    end
    assign tag_read  = tag_mem[tag_req.index];
    assign data_read = data_mem[data_req.index];

    // Main memory and the reference flat memory (what the CPU should observe).
    logic [127:0] main_mem [logic [31:0]];
    logic [127:0] ref_mem  [logic [31:0]];

    function automatic logic [127:0] init_line(input logic [31:0] a);
        return {a ^ 32'h1357_9BDF, ~a, a + 32'h0101_0101, a ^ 32'hCAFE_0000};
    endfunction
    function automatic logic [127:0] main_line(input logic [31:0] a);
        return main_mem.exists(a) ? main_mem[a] : init_line(a);
    endfunction
    function automatic logic [127:0] ref_line(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    // Memory responder: random wait, single-cycle ready pulse, checks request stability.
    xfer_t mem_log [$];
    xfer_t cur;
    logic  xfer_active = 1'b0;
    logic  mem_hold    = 1'b0;
    int    mem_busy    = 0;
    int    wait_cnt    = 1;

    initial begin
        mem_data = '0;
        forever begin
            @(negedge clk);
            mem_data.ready = 1'b0;
            if (mem_req.valid) begin
                mem_busy++;
                if (!xfer_active) begin
                    xfer_active = 1'b1;
                    cur = '{mem_req.addr, mem_req.rw, mem_req.data};
                end else begin
                    chk("mem_req_stable", 128'({mem_req.addr, mem_req.rw}), 128'({cur.addr, cur.rw}));
                end
                if (!mem_hold) begin
                    if (wait_cnt == 0) begin
                        mem_log.push_back(cur);
                        if (cur.rw) main_mem[cur.addr] = cur.data;
                        else        mem_data.data = main_line(cur.addr);
                        mem_data.ready = 1'b1;
                        xfer_active = 1'b0;
                        wait_cnt = int'($urandom_range(0, 3));
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                xfer_active = 1'b0;
            end
        end
    end

    // Reference cache directory: which line each index holds, and whether it is dirty.
    logic        ref_valid [CACHE_INDEX];
    logic [17:0] ref_tag   [CACHE_INDEX];
    logic        ref_dirty [CACHE_INDEX];
    int          exp_hits = 0, exp_misses = 0;
    int          last_lat;
    cache_tag_type  last_tw;
    cache_data_type last_dw;
    logic           last_we;

    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic rw,
                          output logic [31:0] rdata);
        logic [9:0]   idx;
        logic [17:0]  tg;
        logic [1:0]   w;
        logic [31:0]  line_addr, old_addr;
        logic [127:0] line, sh_line;
        logic         exp_hit, exp_wb, got;
        int           busy0, lat, exp_n;
        xfer_t        x;
        idx       = addr[13:4];
        tg        = addr[31:14];
        w         = addr[3:2];
        line_addr = {addr[31:4], 4'h0};
        exp_hit   = ref_valid[idx] && (ref_tag[idx] == tg);
        exp_wb    = !exp_hit && ref_valid[idx] && ref_dirty[idx];
        old_addr  = {ref_tag[idx], idx, 4'h0};
        exp_n     = exp_hit ? 0 : (exp_wb ? 2 : 1);
        mem_log.delete();
        busy0 = mem_busy;
        rdata = '0;

        @(negedge clk);
        cpu_req = '{addr, wdata, rw, 1'b1};
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            cpu_req.valid = 1'b0;
            lat++;
            if (cpu_res.ready) begin
                got     = 1'b1;
                rdata   = cpu_res.data;
                last_tw = tag_write;
                last_dw = data_write;
                last_we = tag_req.we && data_req.we;
            end
        end
        last_lat = lat;
        chk("resp_seen", 128'(got), 128'(1));
        chk("latency", 128'(lat), 128'(exp_hit ? 1 : 2 + mem_busy - busy0));
        chk("xfer_count", 128'(mem_log.size()), 128'(exp_n));
        if (exp_wb && mem_log.size() == 2) begin
            x = mem_log[0];
            chk("wb_addr", 128'(x.addr), 128'(old_addr));
            chk("wb_rw", 128'(x.rw), 128'(1));
            chk("wb_data", x.data, ref_line(old_addr));
        end
        if (!exp_hit && mem_log.size() == exp_n) begin
            x = mem_log[exp_n-1];
            chk("fill_addr", 128'(x.addr), 128'(line_addr));
            chk("fill_rw", 128'(x.rw), 128'(0));
        end

        line = ref_line(line_addr);
        if (!rw) begin
            sh_line = line >> (32 * int'(w));
            chk("rdata", 128'(rdata), 128'(sh_line[31:0]));
        end else begin
            line = (line & ~(128'hFFFF_FFFF << (32 * int'(w)))) | (128'(wdata) << (32 * int'(w)));
            ref_mem[line_addr] = line;
        end
        ref_dirty[idx] = exp_hit ? (ref_dirty[idx] | rw) : rw;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
        if (exp_hit) exp_hits++;
        else         exp_misses++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  idx_tab [4];
        logic [31:0] a;
        xfer_t       x;
        idx_tab[0] = 10'h100; idx_tab[1] = 10'h101; idx_tab[2] = 10'h3FF; idx_tab[3] = 10'h000;
        for (int i = 0; i < CACHE_INDEX; i++) begin
            ref_valid[i] = 1'b0; ref_tag[i] = '0; ref_dirty[i] = 1'b0;
        end
        cpu_req = '0;
        rst_n   = 1'b0;
        main_mem[32'h1000] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        ref_mem[32'h1000]  = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        repeat (3) @(negedge clk);
        chk("rst_cpu_res", 128'(cpu_res), 128'(0));
        chk("rst_mem_req", 128'(mem_req.valid), 128'(0));
        chk("rst_mem_addr", 128'(mem_req.addr), 128'(0));
        chk("rst_tag_req", 128'({tag_req, data_req}), 128'(0));
        chk("rst_writes", 128'(tag_write) | data_write, 128'(0));
        rst_n = 1'b1;

        do_req(32'h0000_1004, 32'h0, 1'b0, rd);
        chk("tp1_data", 128'(rd), 128'(32'h2222_2222));
        if (mem_log.size() == 1) begin
            x = mem_log[0];
            chk("tp1_mem_addr", 128'(x.addr), 128'(32'h0000_1000));
            chk("tp1_mem_rw", 128'(x.rw), 128'(0));
        end

        do_req(32'h0000_1004, 32'h0, 1'b0, rd);
        chk("tp2_lat", 128'(last_lat), 128'(1));
        chk("tp2_no_mem", 128'(mem_log.size()), 128'(0));

        do_req(32'h0000_1008, 32'hDEAD_BEEF, 1'b1, rd);
        chk("tp3_tag_write", 128'(last_tw), 128'(20'hC0000));
        chk("tp3_data_word2", 128'(last_dw[95:64]), 128'(32'hDEAD_BEEF));
        chk("tp3_we", 128'(last_we), 128'(1));

        do_req(32'h0000_5008, 32'h0, 1'b0, rd);
        if (mem_log.size() == 2) begin
            x = mem_log[0];
            chk("tp4_wb_addr", 128'(x.addr), 128'(32'h0000_1000));
            chk("tp4_wb_word2", 128'(x.data[95:64]), 128'(32'hDEAD_BEEF));
            x = mem_log[1];
            chk("tp4_fill_addr", 128'(x.addr), 128'(32'h0000_5000));
        end
`ifdef CACHE_STATS_EN
        chk("tp_hit_cnt", 128'(hit_cnt), 128'(2));
        chk("tp_miss_cnt", 128'(miss_cnt), 128'(2));
`endif

        for (int n = 0; n < 150; n++) begin
            a = {14'($urandom_range(0, 3)), idx_tab[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), 2'b00};
            do_req(a, $urandom, 1'($urandom_range(0, 1)), rd);
        end
`ifdef CACHE_STATS_EN
        chk("rand_hit_cnt", 128'(hit_cnt), 128'(exp_hits));
        chk("rand_miss_cnt", 128'(miss_cnt), 128'(exp_misses));
`endif

        // Reset in the middle of a fill: memory is held so the DUT parks in ALLOCATE.
        @(negedge clk);
        mem_hold = 1'b1;
        cpu_req  = '{32'h0000_2000, 32'h0, 1'b0, 1'b1};
        @(posedge clk);
        @(negedge clk);
        cpu_req.valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("alloc_pending", 128'(mem_req.valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(mem_req.valid), 128'(0));
        chk("rst_mid_ready", 128'(cpu_res.ready), 128'(0));
        chk("rst_mid_we", 128'({tag_req.we, data_req.we}), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 128'(cpu_res.ready), 128'(0));
        chk("post_rst_valid", 128'(mem_req.valid), 128'(0));
        mem_hold = 1'b0;
`ifdef CACHE_STATS_EN
        chk("post_rst_hits", 128'(hit_cnt), 128'(0));
`endif
        do_req(32'h0000_2000, 32'h0, 1'b0, rd);
        do_req(32'h0000_2004, 32'h0, 1'b0, rd);
        chk("post_rst_hit_lat", 128'(last_lat), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
